// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE controller: FSM encoding and default sizing.
package pe_ctrl_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_L_RAM_SIZE = 4;
  localparam int DEF_TIMEOUT    = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  // States in which a run is in progress and start must be ignored.
  function automatic logic is_busy(input state_t s);
    return s inside {S_LOAD, S_FETCH, S_ISSUE, S_WAIT};
  endfunction

endpackage

// File: rtl/pe_ctrl_wdog.sv
// Watchdog for the WAIT state: counts enabled cycles, flags when the budget is used up.
module pe_ctrl_wdog
  import pe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // expired is raised during the TIMEOUT-th enabled cycle so the FSM leaves on that edge.
  assign expired = (cnt == CW'(TIMEOUT - 1));

  // Cycle counter; saturates at the expiry value rather than wrapping.
  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (areset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pe_ctrl.sv
// Controller that loads N weights into a PE's local RAM, then streams N operands
// through the PE one at a time and reports the final accumulated result.
module pe_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int L_RAM_SIZE = DEF_L_RAM_SIZE,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_W-1:0]     result,
  input  logic                  s_din_valid,
  output logic                  s_din_ready,
  input  logic [DATA_W-1:0]     s_din_data,
  input  logic                  s_ain_valid,
  output logic                  s_ain_ready,
  input  logic [DATA_W-1:0]     s_ain_data,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic                  pe_we,
  output logic [DATA_W-1:0]     pe_din,
  output logic [DATA_W-1:0]     pe_ain,
  output logic                  pe_valid,
  input  logic                  pe_dvalid,
  input  logic [DATA_W-1:0]     pe_dout
);

  state_t                state, state_nxt;
  logic [L_RAM_SIZE-1:0] k;
  logic                  din_hs, ain_hs, last_k;
  logic                  wd_expired;

  // Ready outputs are registered and only high in their own state, so they qualify the handshake.
  assign din_hs = s_din_valid && s_din_ready;
  assign ain_hs = s_ain_valid && s_ain_ready;
  assign last_k = (k == '1);

  pe_ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .aclk    (aclk),
    .areset  (areset),
    .clear   (state != S_WAIT),
    .enable  (state == S_WAIT),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; pe_dvalid is only looked at in WAIT.
  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE, S_ERR: if (start) state_nxt = S_LOAD;
      S_LOAD:        if (din_hs && last_k) state_nxt = S_FETCH;
      S_FETCH:       if (ain_hs) state_nxt = S_ISSUE;
      S_ISSUE:       state_nxt = S_WAIT;
      S_WAIT: begin
        if (pe_dvalid)       state_nxt = last_k ? S_DONE : S_FETCH;
        else if (wd_expired) state_nxt = S_ERR;
      end
      S_DONE:        state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and datapath; status flags decode the state being entered.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      k           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      result      <= '0;
      s_din_ready <= 1'b0;
      s_ain_ready <= 1'b0;
      pe_addr     <= '0;
      pe_we       <= 1'b0;
      pe_din      <= '0;
      pe_ain      <= '0;
      pe_valid    <= 1'b0;
    end else begin
      busy        <= is_busy(state_nxt);
      done        <= (state_nxt == S_DONE);
      error       <= (state_nxt == S_ERR);
      s_din_ready <= (state_nxt == S_LOAD);
      s_ain_ready <= (state_nxt == S_FETCH);
      pe_valid    <= (state_nxt == S_ISSUE);
      pe_we       <= 1'b0;
      case (state)
        S_IDLE, S_ERR: if (start) k <= '0;
        S_LOAD: begin
          if (din_hs) begin
            pe_we   <= 1'b1;
            pe_addr <= k;
            pe_din  <= s_din_data;
            k       <= last_k ? '0 : k + 1'b1;
          end
        end
        S_FETCH: begin
          if (ain_hs) begin
            pe_ain  <= s_ain_data;
            pe_addr <= k;
          end
        end
        S_WAIT: begin
          if (pe_dvalid) begin
            result <= pe_dout;
            if (!last_k) k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_ctrl.sv
// Self-checking bench for pe_ctrl: directed runs with a scoreboard-driven monitor.
module tb_pe_ctrl;
  import pe_ctrl_pkg::*;

  localparam int L  = DEF_L_RAM_SIZE;
  localparam int DW = DEF_DATA_W;
  localparam int TO = DEF_TIMEOUT;
  localparam int N  = 2 ** L;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [DW-1:0] result;
  logic          s_din_valid = 1'b0;
  logic          s_din_ready;
  logic [DW-1:0] s_din_data = '0;
  logic          s_ain_valid = 1'b0;
  logic          s_ain_ready;
  logic [DW-1:0] s_ain_data = '0;
  logic [L-1:0]  pe_addr;
  logic          pe_we;
  logic [DW-1:0] pe_din, pe_ain;
  logic          pe_valid;
  logic          pe_dvalid = 1'b0;
  logic [DW-1:0] pe_dout = '0;

  pe_ctrl #(.L_RAM_SIZE(L), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset), .start(start), .busy(busy), .done(done),
    .error(error), .result(result),
    .s_din_valid(s_din_valid), .s_din_ready(s_din_ready), .s_din_data(s_din_data),
    .s_ain_valid(s_ain_valid), .s_ain_ready(s_ain_ready), .s_ain_data(s_ain_data),
    .pe_addr(pe_addr), .pe_we(pe_we), .pe_din(pe_din), .pe_ain(pe_ain),
    .pe_valid(pe_valid), .pe_dvalid(pe_dvalid), .pe_dout(pe_dout)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [L-1:0]  addr;
    logic [DW-1:0] data;
  } xfer_t;

  xfer_t         wr_q[$];
  xfer_t         iss_q[$];
  logic [DW-1:0] res_q[$];

  int      n_checks = 0;
  int      n_fail = 0;
  longint  cyc = 0;
  longint  dv_cyc = -10;
  int      we_run = 0;
  int      max_run = 0;
  logic    prev_valid = 1'b0;
  logic    prev_done = 1'b0;
  logic    pe_mute = 1'b0;
  logic [DW-1:0] acc = '0;
  xfer_t   mx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  always @(posedge aclk) cyc++;

  // Monitor: pops the scoreboard whenever the DUT presents a write, an issue or a completion.
  always @(negedge aclk) begin
    if (!areset) begin
      if (pe_we) begin
        we_run++;
        if (we_run > max_run) max_run = we_run;
        if (wr_q.size() == 0) flag("unexpected pe_we");
        else begin
          mx = wr_q.pop_front();
          check("write addr", 64'(pe_addr), 64'(mx.addr));
          check("write data", 64'(pe_din), 64'(mx.data));
        end
      end else begin
        we_run = 0;
      end
      if (pe_valid) begin
        check("pe_valid single cycle", 64'(prev_valid), 64'(0));
        if (iss_q.size() == 0) flag("unexpected pe_valid");
        else begin
          mx = iss_q.pop_front();
          check("issue addr", 64'(pe_addr), 64'(mx.addr));
          check("issue operand", 64'(pe_ain), 64'(mx.data));
        end
      end
      if (done) begin
        check("done single cycle", 64'(prev_done), 64'(0));
        check("done one cycle after last dvalid", 64'(cyc), 64'(dv_cyc + 1));
        if (res_q.size() == 0) flag("unexpected done");
        else check("result", 64'(result), 64'(res_q.pop_front()));
      end
    end
    prev_valid = pe_valid;
    prev_done  = done;
  end

  // PE model: accumulates operands, answers each pe_valid with dvalid three cycles later.
  initial forever begin
    logic [L-1:0] a;
    @(negedge aclk);
    if (pe_valid && !areset && !pe_mute) begin
      acc = acc + pe_ain;
      a   = pe_addr;
      repeat (3) @(posedge aclk);
      #1;
      pe_dvalid = 1'b1;
      pe_dout   = acc;
      dv_cyc    = cyc;
      check("addr held through WAIT", 64'(pe_addr), 64'(a));
      @(posedge aclk);
      #1 pe_dvalid = 1'b0;
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return s_din_ready;
      1:       return s_ain_ready;
      2:       return pe_valid;
      default: return done;
    endcase
  endfunction

  task automatic wait_high(input string name, input int sel);
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (sig(sel)) return;
    end
    flag({name, " wait timed out"});
  endtask

  task automatic pulse_start();
    @(negedge aclk) start = 1'b1;
    @(negedge aclk) start = 1'b0;
  endtask

  task automatic load();
    max_run = 0;
    pulse_start();
    wait_high("s_din_ready", 0);
    for (int i = 0; i < N; i++) begin
      s_din_valid = 1'b1;
      s_din_data  = DW'(i + 1);
      wr_q.push_back('{addr: L'(i), data: DW'(i + 1)});
      @(negedge aclk);
    end
    check("s_din_ready low after N words", 64'(s_din_ready), 64'(0));
    s_din_data = 32'h11;
    @(negedge aclk);
    s_din_valid = 1'b0;
    @(negedge aclk);
    check("pe_we consecutive run", 64'(max_run), 64'(16));
    check("no extra write", 64'(wr_q.size()), 64'(0));
  endtask

  task automatic send_ain(input int idx, input logic [DW-1:0] d, input int gap,
                          input bit stray, input logic [DW-1:0] partial);
    wait_high("s_ain_ready", 1);
    for (int g = 0; g < gap; g++) begin
      check("no pe_valid during gap", 64'(pe_valid), 64'(0));
      if (stray && g == 1) begin
        pe_dvalid = 1'b1;
        pe_dout   = 32'hDEAD_BEEF;
      end
      @(negedge aclk);
      if (stray && g == 1) begin
        pe_dvalid = 1'b0;
        check("stray dvalid keeps FETCH", 64'(s_ain_ready), 64'(1));
        check("stray dvalid keeps result", 64'(result), 64'(partial));
      end
    end
    s_ain_valid = 1'b1;
    s_ain_data  = d;
    iss_q.push_back('{addr: L'(idx), data: d});
    @(posedge aclk);
    #1 s_ain_valid = 1'b0;
  endtask

  // Operands are 4 for the first 15 words and 6 for the last: 15*4 + 6 = 0x42.
  task automatic run(input int gap_idx, input int gap_len, input bit stray);
    acc = '0;
    load();
    res_q.push_back(32'h42);
    for (int i = 0; i < N; i++)
      send_ain(i, (i == N - 1) ? 32'd6 : 32'd4, (i == gap_idx) ? gap_len : 0,
               stray && (i == gap_idx), DW'(4 * i));
    wait_high("done", 3);
    repeat (2) @(negedge aclk);
    check("result held after done", 64'(result), 64'h42);
    check("idle after done", 64'({busy, done, error}), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " flags"}, 64'({busy, done, error, s_din_ready, s_ain_ready, pe_we, pe_valid}), 64'(0));
    check({tag, " result"}, 64'(result), 64'(0));
    check({tag, " pe_addr"}, 64'(pe_addr), 64'(0));
    check({tag, " pe_din/pe_ain"}, {pe_din, pe_ain}, 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (2) @(negedge aclk);
    check_all_zero("reset");
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    check("idle busy", 64'(busy), 64'(0));

    // Plain load + compute.
    run(-1, 0, 1'b0);

    // Start while busy is ignored; reset mid-WAIT clears everything at once.
    pe_mute = 1'b1;
    load();
    pulse_start();
    check("busy start ignored: din_ready", 64'(s_din_ready), 64'(0));
    check("busy start ignored: ain_ready", 64'(s_ain_ready), 64'(1));
    send_ain(0, 32'd4, 0, 1'b0, '0);
    wait_high("pe_valid", 2);
    @(negedge aclk);
    #2 areset = 1'b1;
    #1 check_all_zero("async reset mid-WAIT");
    @(negedge aclk) areset = 1'b0;
    pe_mute = 1'b0;

    // Reload from address 0, 5-cycle operand gap with a stray dvalid in FETCH.
    run(5, 5, 1'b1);

    // PE never answers: error exactly TIMEOUT cycles into WAIT.
    pe_mute = 1'b1;
    load();
    send_ain(0, 32'd4, 0, 1'b0, '0);
    wait_high("pe_valid", 2);
    @(posedge aclk);
    repeat (TO - 1) @(posedge aclk);
    #1;
    check("no error before timeout", 64'({error, busy}), 64'b01);
    @(posedge aclk);
    #1;
    check("error at timeout", 64'({error, busy}), 64'b10);
    repeat (3) @(negedge aclk);
    check("error sticky", 64'(error), 64'(1));
    pulse_start();
    check("start clears error", 64'({error, busy, s_din_ready}), 64'b011);
    @(negedge aclk) areset = 1'b1;
    @(negedge aclk) areset = 1'b0;
    pe_mute = 1'b0;

    repeat (2) @(negedge aclk);
    check("issue queue drained", 64'(iss_q.size()), 64'(0));
    check("result queue drained", 64'(res_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
